// File: rtl/shift_unit_iterative.sv
// Iterative shifter: one bit position per clock, valid/ready on both sides.
// Results match the combinational ALU shifter for Lsl, Lsr and Asr; the
// reserved operation returns the operand unchanged with out_err set.
module shift_unit_iterative #(
  parameter int DATA_WIDTH   = 32,
  parameter int AMOUNT_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic [AMOUNT_WIDTH-1:0] in_amount,
  input  logic [1:0]              in_oper,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_err
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [1:0] OPER_LSL  = 2'd0;
  localparam logic [1:0] OPER_LSR  = 2'd1;
  localparam logic [1:0] OPER_ASR  = 2'd2;
  localparam logic [1:0] OPER_RSVD = 2'd3;

  state_t                  state_q;
  state_t                  state_d;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [AMOUNT_WIDTH-1:0] count_q;
  logic [1:0]              oper_q;
  logic                    err_q;

  // A request is taken only from IDLE, and flush always wins over it.
  logic accept;
  logic shift_step;
  assign accept     = (state_q == IDLE) && in_valid && !flush;
  assign shift_step = (state_q == SHIFT) && !flush;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values, independent of the order the blocks are evaluated in.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    // NOTE: every output of this block is given a default first; a path that
    // leaves one unassigned would infer a latch.
    state_d   = state_q;
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (in_amount == '0 || in_oper == OPER_RSVD) state_d = DONE;
          else                                         state_d = SHIFT;
        end
      end
      SHIFT: begin
        // count_q is the number of shifts still to do, including this edge.
        if (count_q == AMOUNT_WIDTH'(1)) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // Operand capture at accept, then one bit of shift per SHIFT cycle.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the datapath registers are reset too, so out_data/out_err read 0
    // after reset rather than whatever the last operation left behind.
    if (rst) begin
      data_q  <= '0;
      count_q <= '0;
      oper_q  <= OPER_LSL;
      err_q   <= 1'b0;
    end else if (accept) begin
      data_q  <= in_data;
      count_q <= in_amount;
      oper_q  <= in_oper;
      err_q   <= (in_oper == OPER_RSVD);
    end else if (shift_step) begin
      count_q <= count_q - AMOUNT_WIDTH'(1);
      unique case (oper_q)
        OPER_LSL: data_q <= {data_q[DATA_WIDTH-2:0], 1'b0};
        OPER_LSR: data_q <= {1'b0, data_q[DATA_WIDTH-1:1]};
        OPER_ASR: data_q <= {data_q[DATA_WIDTH-1], data_q[DATA_WIDTH-1:1]};
        default:  data_q <= data_q;
      endcase
    end
  end

  // The result register doubles as the shift register; it is only
  // meaningful while out_valid is high and holds its value in IDLE.
  assign out_data = data_q;
  assign out_err  = err_q;

endmodule

// File: tb/tb_shift_unit_iterative.sv
// Self-checking bench for shift_unit_iterative: expected results and
// latencies are pushed to a scoreboard at accept and popped at out_valid.
module tb_shift_unit_iterative;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [AW-1:0] in_amount;
  logic [1:0]    in_oper;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_err;

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    int            lat;
  } exp_t;

  exp_t sb[$];
  int   vectors;
  int   miscompares;

  shift_unit_iterative #(.DATA_WIDTH(DW), .AMOUNT_WIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amount (in_amount),
    .in_oper   (in_oper),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] model(input logic [DW-1:0] d,
                                          input logic [AW-1:0] a,
                                          input logic [1:0] op);
    logic [DW-1:0] r;
    case (op)
      2'd0:    r = d << a;
      2'd1:    r = d >> a;
      2'd2:    r = $signed(d) >>> a;
      default: r = d;
    endcase
    return r;
  endfunction

  // Issue one request, wait for its result, optionally stall the consumer
  // for 'stall' cycles, then complete the handshake.
  task automatic run_op(input string name, input logic [DW-1:0] d,
                        input logic [AW-1:0] a, input logic [1:0] op,
                        input int stall);
    exp_t e;
    exp_t got;
    int   lat;
    bit   seen;
    e.data = model(d, a, op);
    e.err  = (op == 2'd3);
    e.lat  = (a == '0 || op == 2'd3) ? 1 : int'(a) + 1;

    @(negedge clk);
    out_ready = (stall == 0);
    in_valid  = 1'b1;
    in_data   = d;
    in_amount = a;
    in_oper   = op;
    for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
    vectors++;
    if (!in_ready) begin
      miscompares++;
      $display("FAIL %s accept: in_ready=%b required 1 within 50 cycles", name, in_ready);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    sb.push_back(e);
    // Scramble the inputs after the accept edge; the unit must ignore them.
    #1;
    in_valid  = 1'b0;
    in_data   = ~d;
    in_amount = ~a;
    in_oper   = op ^ 2'd1;

    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 100) begin
      @(negedge clk);
      lat++;
      if (out_valid) seen = 1'b1;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL %s timeout: out_valid never rose in 100 cycles", name);
      out_ready = 1'b1;
      return;
    end
    got = sb.pop_front();
    if (lat !== got.lat) begin
      miscompares++;
      $display("FAIL %s latency: got %0d required %0d", name, lat, got.lat);
    end
    vectors++;
    if (out_data !== got.data) begin
      miscompares++;
      $display("FAIL %s data: got %h required %h", name, out_data, got.data);
    end
    vectors++;
    if (out_err !== got.err || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL %s err/in_ready: got %b/%b required %b/0", name, out_err, in_ready, got.err);
    end

    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== got.data || out_err !== got.err) begin
        miscompares++;
        $display("FAIL %s hold[%0d]: valid=%b ready=%b data=%h err=%b required 1 0 %h %b",
                 name, i, out_valid, in_ready, out_data, out_err, got.data, got.err);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s release: valid=%b in_ready=%b required 0 1", name, out_valid, in_ready);
    end
  endtask

  task automatic expect_quiet(input string name, input int cycles);
    bit rose;
    rose = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b1) rose = 1'b1;
    end
    vectors++;
    if (rose) begin
      miscompares++;
      $display("FAIL %s quiet: out_valid/in_ready left 0/1 within %0d cycles", name, cycles);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0 || out_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: ready=%b valid=%b data=%h err=%b required 1 0 0 0",
               in_ready, out_valid, out_data, out_err);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_shift_ops();
    run_op("lsl31", 32'h0000_0001, 5'd31, 2'd0, 0);
    run_op("asr4",  32'h8000_0000, 5'd4,  2'd2, 0);
    run_op("lsr4",  32'h8000_0000, 5'd4,  2'd1, 0);
    run_op("asr31", 32'h8000_0000, 5'd31, 2'd2, 0);
    run_op("lsr1",  32'hFFFF_FFFF, 5'd1,  2'd1, 0);
  endtask

  task automatic test_short_path();
    run_op("amt0",  32'h1234_5678, 5'd0, 2'd1, 0);
    run_op("rsvd",  32'hDEAD_BEEF, 5'd7, 2'd3, 0);
  endtask

  task automatic test_backpressure();
    run_op("bp", 32'h0000_00FF, 5'd8, 2'd0, 10);
  endtask

  task automatic test_flush();
    // Flush three cycles into a long Asr; no result may ever appear.
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h8000_0000;
    in_amount = 5'd20;
    in_oper   = 2'd2;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(negedge clk);
    flush     = 1'b1;
    @(negedge clk);
    // Unit is back in IDLE; present a request while flush is still high.
    in_valid  = 1'b1;
    in_data   = 32'h0000_0003;
    in_amount = 5'd0;
    in_oper   = 2'd0;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_shift: valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    expect_quiet("flush_ignore", 30);

    // Flush a pending result in DONE.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hCAFE_F00D;
    in_amount = 5'd0;
    in_oper   = 2'd0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_done_pre: out_valid=%b required 1", out_valid);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_done: valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
    out_ready = 1'b1;
    run_op("post_flush", 32'h0000_00F0, 5'd4, 2'd1, 0);
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h0000_000A;
    in_amount = 5'd10;
    in_oper   = 2'd0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0 || out_err !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: valid=%b ready=%b data=%h err=%b required 0 1 0 0",
               out_valid, in_ready, out_data, out_err);
    end
    @(negedge clk);
    rst = 1'b0;
    expect_quiet("after_reset", 15);
    run_op("lsl1", 32'h0000_0001, 5'd1, 2'd0, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      logic [DW-1:0] d;
      logic [AW-1:0] a;
      logic [1:0]    op;
      d  = $urandom;
      a  = AW'($urandom_range(0, DW - 1));
      op = 2'($urandom_range(0, 3));
      run_op($sformatf("rand%0d", i), d, a, op, int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    flush       = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    in_amount   = '0;
    in_oper     = 2'd0;
    out_ready   = 1'b1;
    test_reset();
    test_shift_ops();
    test_short_path();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_back_to_back();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard: %0d results left unconsumed, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
